// File: rtl/sync_window_counter.sv
// sync_window_counter
//   Line position counter restarted by the rising edge of a line strobe (sync).
//   Counts 0..lim_s in one-shot or continuous mode and flags a programmable
//   sampling window for downstream capture logic.
//
// Ports
//   clk        system clock, all state on posedge
//   rst        synchronous active-low reset
//   en         count enable (does not gate the sync restart)
//   sync       line strobe, rising edge restarts the count
//   mode       0 = one-shot, 1 = continuous (wrap at limit)
//   limit      terminal count (inclusive), captured on sync edge
//   win_start  first counter value inside the window (live)
//   win_end    last counter value inside the window (live)
//   counter    current count
//   busy       high in ARM and COUNT
//   done       one-cycle pulse at terminal count
//   in_window  window flag, combinational from registered state/counter
//   overrun    one-cycle pulse when a sync edge arrives while busy
module sync_window_counter #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic              mode,
  input  logic [DWIDTH-1:0] limit,
  input  logic [DWIDTH-1:0] win_start,
  input  logic [DWIDTH-1:0] win_end,
  output logic [DWIDTH-1:0] counter,
  output logic              busy,
  output logic              done,
  output logic              in_window,
  output logic              overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] lim_s_q, lim_s_d;
  logic              mode_s_q, mode_s_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              sync_q;
  logic              sync_edge;

  assign sync_edge = sync & ~sync_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lim_s_d  = lim_s_q;
    mode_s_d = mode_s_q;
    done_d   = 1'b0;
    ovr_d    = 1'b0;
    if (sync_edge) begin
      // Restart wins over a coincident terminal count: no done pulse then.
      state_d  = S_ARM;
      cnt_d    = '0;
      lim_s_d  = limit;
      mode_s_d = mode;
      ovr_d    = (state_q == S_ARM) || (state_q == S_COUNT);
    end else begin
      case (state_q)
        S_ARM:   state_d = S_COUNT;
        S_COUNT: begin
          if (en) begin
            if (cnt_q == lim_s_q) begin
              done_d = 1'b1;
              if (mode_s_q) cnt_d = '0;
              else          state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ; // IDLE and DONE wait for the next sync edge
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lim_s_q  <= '0;
      mode_s_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      // Keep tracking the strobe through reset so a sync held high across
      // reset release is not mistaken for a fresh edge.
      sync_q   <= sync;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lim_s_q  <= lim_s_d;
      mode_s_q <= mode_s_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      sync_q   <= sync;
    end
  end

  assign counter   = cnt_q;
  assign busy      = (state_q == S_ARM) || (state_q == S_COUNT);
  assign done      = done_q;
  assign overrun   = ovr_q;
  assign in_window = (state_q == S_COUNT) && (cnt_q >= win_start) && (cnt_q <= win_end);

endmodule

// File: tb/tb_sync_window_counter.sv
module tb_sync_window_counter;

  logic       clk = 1'b0;
  logic       rst, en, sync, mode;
  logic [7:0] limit, win_start, win_end;
  logic [7:0] counter;
  logic       busy, done, in_window, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_window_counter #(.DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .mode(mode), .limit(limit),
    .win_start(win_start), .win_end(win_end), .counter(counter), .busy(busy),
    .done(done), .in_window(in_window), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int d,
                         input int o);
    chk({tag, ".counter"}, 32'(counter), c);
    chk({tag, ".busy"},    32'(busy),    b);
    chk({tag, ".done"},    32'(done),    d);
    chk({tag, ".overrun"}, 32'(overrun), o);
  endtask

  int exp3 [10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    // 1: reset with sync and en high; no start after release
    rst = 1'b0; en = 1'b1; sync = 1'b1; mode = 1'b0; limit = 8'd5;
    win_start = 8'd0; win_end = 8'd0;
    tick(); tick();
    chk_all("reset", 0, 0, 0, 0);
    rst = 1'b1;
    tick(); tick();
    chk_all("post_reset_sync_high", 0, 0, 0, 0);
    sync = 1'b0;
    tick();

    // 2: one-shot, limit 5
    mode = 1'b0; limit = 8'd5; sync = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_all("oneshot5", (i < 2) ? 0 : i - 1, 1, 0, 0);
    end
    tick();
    chk_all("oneshot5_term", 5, 0, 1, 0);
    tick();
    chk_all("oneshot5_hold", 5, 0, 0, 0);
    sync = 1'b0;
    tick();

    // 3: continuous, limit 3
    mode = 1'b1; limit = 8'd3; sync = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("cont3", exp3[i], 1, (i == 5 || i == 9) ? 1 : 0, 0);
    end
    sync = 1'b0;
    tick();

    // 4: one-shot limit 10; re-sync at counter 4 (first edge also hits a busy run)
    mode = 1'b0; limit = 8'd10; sync = 1'b1;
    tick();
    chk_all("restart_from_cont", 0, 1, 0, 1);
    sync = 1'b0;
    repeat (5) tick();
    chk_all("at4", 4, 1, 0, 0);
    sync = 1'b1;
    tick();
    chk_all("overrun_arm", 0, 1, 0, 1);
    tick();
    chk_all("overrun_clear", 0, 1, 0, 0);
    repeat (10) tick();
    chk_all("recount10", 10, 1, 0, 0);
    tick();
    chk_all("recount10_term", 10, 0, 1, 0);
    tick();
    chk_all("recount10_hold", 10, 0, 0, 0);
    sync = 1'b0;
    tick();

    // 5: window 2..4 with en dropped at 3
    mode = 1'b0; limit = 8'd6; win_start = 8'd2; win_end = 8'd4; sync = 1'b1;
    tick();
    chk("win_arm", 32'(in_window), 0);
    sync = 1'b0;
    for (int v = 0; v <= 3; v++) begin
      tick();
      chk("win_cnt", 32'(counter), v);
      chk("win_flag", 32'(in_window), (v >= 2) ? 1 : 0);
    end
    en = 1'b0;
    repeat (3) begin
      tick();
      chk("win_hold_cnt", 32'(counter), 3);
      chk("win_hold_flag", 32'(in_window), 1);
    end
    en = 1'b1;
    for (int v = 4; v <= 6; v++) begin
      tick();
      chk("win_cnt2", 32'(counter), v);
      chk("win_flag2", 32'(in_window), (v <= 4) ? 1 : 0);
    end
    win_end = 8'd6;
    tick();
    chk_all("win_done", 6, 0, 1, 0);
    chk("win_flag_done_state", 32'(in_window), 0);

    // 6: limit change mid-count is ignored; inverted window never asserts
    mode = 1'b0; limit = 8'd8; sync = 1'b1;
    tick();
    sync = 1'b0;
    tick(); tick();
    chk("lim_chg_at1", 32'(counter), 1);
    limit = 8'd2; win_start = 8'd5; win_end = 8'd3;
    repeat (3) tick();
    chk("inv_window_cnt", 32'(counter), 4);
    chk("inv_window_flag", 32'(in_window), 0);
    repeat (4) tick();
    chk_all("lim_chg_at8", 8, 1, 0, 0);
    tick();
    chk_all("lim_chg_term", 8, 0, 1, 0);

    // limit 0, continuous: counter stays 0, done every cycle from k+2
    mode = 1'b1; limit = 8'd0; sync = 1'b1;
    tick();
    chk_all("lim0_arm", 0, 1, 0, 0);
    sync = 1'b0;
    tick();
    chk_all("lim0_first", 0, 1, 0, 0);
    repeat (4) begin
      tick();
      chk_all("lim0_run", 0, 1, 1, 0);
    end

    // limit 255 one-shot: full-range terminal count, no wrap
    mode = 1'b0; limit = 8'd255; sync = 1'b1;
    tick();
    chk_all("lim255_arm", 0, 1, 0, 1);
    sync = 1'b0;
    tick();
    repeat (255) tick();
    chk_all("lim255_last", 255, 1, 0, 0);
    tick();
    chk_all("lim255_term", 255, 0, 1, 0);

    // reset mid-count aborts without done
    limit = 8'd10; sync = 1'b1;
    tick();
    sync = 1'b0;
    repeat (4) tick();
    chk("pre_abort_cnt", 32'(counter), 3);
    rst = 1'b0;
    tick();
    chk_all("abort", 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_all("abort_idle", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
